// File: rtl/apb_kernel_splitter_if.sv
// Bus bundle for apb_kernel_splitter: upstream APB slave port plus shared and per-slave downstream APB signals.
// Handshake: a transfer is one setup cycle (psel=1, penable=0) followed by access cycles (penable=1) until pready=1.
interface apb_kernel_splitter_if #(
  parameter int APB_ADDR_WIDTH  = 32,
  parameter int APB_DATA_WIDTH  = 32,
  parameter int APB_PPROT_WIDTH = 3,
  parameter int APB_PSTRB_WIDTH = 4,
  parameter int NUM_SLAVES      = 4
);
  logic [APB_ADDR_WIDTH-1:0]            s_apb_paddr;
  logic                                 s_apb_psel;
  logic                                 s_apb_penable;
  logic                                 s_apb_pwrite;
  logic [APB_DATA_WIDTH-1:0]            s_apb_pwdata;
  logic [APB_PSTRB_WIDTH-1:0]           s_apb_pstrb;
  logic [APB_PPROT_WIDTH-1:0]           s_apb_pprot;
  logic [APB_DATA_WIDTH-1:0]            s_apb_prdata;
  logic                                 s_apb_pready;
  logic                                 s_apb_pslverr;

  logic [APB_ADDR_WIDTH-1:0]            m_apb_paddr;
  logic [NUM_SLAVES-1:0]                m_apb_psel;
  logic                                 m_apb_penable;
  logic                                 m_apb_pwrite;
  logic [APB_DATA_WIDTH-1:0]            m_apb_pwdata;
  logic [APB_PSTRB_WIDTH-1:0]           m_apb_pstrb;
  logic [APB_PPROT_WIDTH-1:0]           m_apb_pprot;
  logic [NUM_SLAVES*APB_DATA_WIDTH-1:0] m_apb_prdata;
  logic [NUM_SLAVES-1:0]                m_apb_pready;
  logic [NUM_SLAVES-1:0]                m_apb_pslverr;

  modport slave (
    input  s_apb_paddr, s_apb_psel, s_apb_penable, s_apb_pwrite, s_apb_pwdata, s_apb_pstrb, s_apb_pprot,
    output s_apb_prdata, s_apb_pready, s_apb_pslverr,
    output m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot,
    input  m_apb_prdata, m_apb_pready, m_apb_pslverr
  );

  modport master (
    output s_apb_paddr, s_apb_psel, s_apb_penable, s_apb_pwrite, s_apb_pwdata, s_apb_pstrb, s_apb_pprot,
    input  s_apb_prdata, s_apb_pready, s_apb_pslverr,
    input  m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot,
    output m_apb_prdata, m_apb_pready, m_apb_pslverr
  );
endinterface

// File: rtl/apb_kernel_splitter.sv
// APB 1-to-N address splitter: decodes one upstream APB transfer into a downstream kernel region,
// with access timeout, decode-error response, saturating error count and sticky status bits.
module apb_kernel_splitter #(
  parameter logic [63:0] APB_BASE_ADDR   = 64'd0,
  parameter int          APB_ADDR_WIDTH  = 32,
  parameter int          APB_DATA_WIDTH  = 32,
  parameter int          APB_PPROT_WIDTH = 3,
  parameter int          APB_PSTRB_WIDTH = 4,
  parameter int          NUM_SLAVES      = 4,
  parameter int          SLAVE_ADDR_BITS = 12,
  parameter int          TIMEOUT_CYCLES  = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  apb_kernel_splitter_if.slave bus,
  output logic [7:0]           out_err_count,
  output logic [3:0]           out_status,
  output logic [2:0]           dbg_state
);
  localparam int AW    = APB_ADDR_WIDTH;
  localparam int DW    = APB_DATA_WIDTH;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [AW-1:0] BASE     = AW'(APB_BASE_ADDR);
  localparam logic [AW-1:0] OFF_MASK = AW'((64'd1 << SLAVE_ADDR_BITS) - 64'd1);
  localparam logic [15:0]   TMO      = 16'(TIMEOUT_CYCLES);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      tcnt;
  logic [7:0]       err_cnt;
  logic             timeout_seen, decerr_seen, slverr_seen, busy;

  logic [AW-1:0]         off, dec_hi;
  logic                  dec_ok;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_oh;
  logic                  sel_pready, sel_pslverr;
  logic [DW-1:0]         sel_prdata;
  logic [15:0]           tcnt_inc;
  logic [7:0]            err_cnt_inc;

  always_comb begin
    off         = bus.s_apb_paddr - BASE;
    dec_hi      = off >> SLAVE_ADDR_BITS;
    dec_ok      = (bus.s_apb_paddr >= BASE) && (dec_hi < AW'(NUM_SLAVES));
    dec_idx     = IDX_W'(dec_hi);
    tcnt_inc    = tcnt + 16'd1;
    err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    dec_oh      = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_oh[i] = (dec_idx == IDX_W'(i));
      if (idx_q == IDX_W'(i)) begin
        sel_pready  = bus.m_apb_pready[i];
        sel_pslverr = bus.m_apb_pslverr[i];
        sel_prdata  = bus.m_apb_prdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= ST_IDLE;
      idx_q             <= '0;
      tcnt              <= '0;
      err_cnt           <= '0;
      timeout_seen      <= 1'b0;
      decerr_seen       <= 1'b0;
      slverr_seen       <= 1'b0;
      busy              <= 1'b0;
      bus.m_apb_paddr   <= '0;
      bus.m_apb_psel    <= '0;
      bus.m_apb_penable <= 1'b0;
      bus.m_apb_pwrite  <= 1'b0;
      bus.m_apb_pwdata  <= '0;
      bus.m_apb_pstrb   <= '0;
      bus.m_apb_pprot   <= '0;
      bus.s_apb_prdata  <= '0;
      bus.s_apb_pready  <= 1'b0;
      bus.s_apb_pslverr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.s_apb_psel && !bus.s_apb_penable) begin
            busy             <= 1'b1;
            idx_q            <= dec_idx;
            bus.m_apb_paddr  <= off & OFF_MASK;
            bus.m_apb_pwrite <= bus.s_apb_pwrite;
            bus.m_apb_pwdata <= bus.s_apb_pwdata;
            bus.m_apb_pstrb  <= bus.s_apb_pwrite ? bus.s_apb_pstrb : '0;
            bus.m_apb_pprot  <= bus.s_apb_pprot;
            if (dec_ok) begin
              state          <= ST_SETUP;
              bus.m_apb_psel <= dec_oh;
            end else begin
              // Unmapped address: answer upstream directly, no downstream select.
              state             <= ST_ERR;
              bus.s_apb_pready  <= 1'b1;
              bus.s_apb_pslverr <= 1'b1;
              bus.s_apb_prdata  <= '0;
              decerr_seen       <= 1'b1;
              err_cnt           <= err_cnt_inc;
            end
          end
        end
        ST_SETUP: begin
          state             <= ST_ACCESS;
          bus.m_apb_penable <= 1'b1;
          tcnt              <= '0;
        end
        ST_ACCESS: begin
          if (sel_pready) begin
            state             <= ST_RESP;
            bus.m_apb_psel    <= '0;
            bus.m_apb_penable <= 1'b0;
            bus.s_apb_pready  <= 1'b1;
            bus.s_apb_prdata  <= sel_prdata;
            bus.s_apb_pslverr <= sel_pslverr;
            if (sel_pslverr) begin
              slverr_seen <= 1'b1;
              err_cnt     <= err_cnt_inc;
            end
          end else if (tcnt_inc == TMO) begin
            // Slave never answered within the window: abort and report an error upstream.
            state             <= ST_RESP;
            bus.m_apb_psel    <= '0;
            bus.m_apb_penable <= 1'b0;
            bus.s_apb_pready  <= 1'b1;
            bus.s_apb_prdata  <= '0;
            bus.s_apb_pslverr <= 1'b1;
            timeout_seen      <= 1'b1;
            err_cnt           <= err_cnt_inc;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        ST_RESP, ST_ERR: begin
          state             <= ST_IDLE;
          busy              <= 1'b0;
          bus.s_apb_pready  <= 1'b0;
          bus.s_apb_pslverr <= 1'b0;
          bus.s_apb_prdata  <= '0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_err_count = err_cnt;
  assign out_status    = {timeout_seen, decerr_seen, slverr_seen, busy};
  assign dbg_state     = state;
endmodule

// File: tb/tb_apb_kernel_splitter.sv
// Directed plus randomized bench for apb_kernel_splitter; expectations come from an address-map and
// response model evaluated per transfer, with a queue of expected upstream responses.
module tb_apb_kernel_splitter;
  localparam int AW = 32, DW = 32, PW = 3, SW = 4, NS = 4, SAB = 12, TMO = 8;
  localparam longint unsigned BASE   = 0;
  localparam longint unsigned REGION = 64'd1 << SAB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] out_err_count;
  logic [3:0] out_status;
  logic [2:0] dbg_state;

  apb_kernel_splitter_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .APB_PPROT_WIDTH(PW),
                           .APB_PSTRB_WIDTH(SW), .NUM_SLAVES(NS)) bus ();

  apb_kernel_splitter #(
    .APB_BASE_ADDR(64'(BASE)), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .APB_PPROT_WIDTH(PW),
    .APB_PSTRB_WIDTH(SW), .NUM_SLAVES(NS), .SLAVE_ADDR_BITS(SAB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .out_err_count(out_err_count), .out_status(out_status), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state and reference model
  int checks = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];
  int m_errs;
  bit m_tmo, m_dec, m_slv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] oh(input int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  function automatic logic [3:0] exp_status();
    return {m_tmo, m_dec, m_slv, 1'b0};
  endfunction

  function automatic logic [7:0] exp_errcnt();
    return (m_errs > 255) ? 8'd255 : 8'(m_errs);
  endfunction

  task automatic model_clear();
    m_errs = 0; m_tmo = 0; m_dec = 0; m_slv = 0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    bus.s_apb_paddr = '0; bus.s_apb_psel = 0; bus.s_apb_penable = 0; bus.s_apb_pwrite = 0;
    bus.s_apb_pwdata = '0; bus.s_apb_pstrb = '0; bus.s_apb_pprot = '0;
    bus.m_apb_prdata = '0; bus.m_apb_pready = '0; bus.m_apb_pslverr = '0;
  endtask

  // driver: one upstream transfer plus an emulated downstream slave; called at a negedge, returns at one
  task automatic do_xfer(input string tag, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                         input int waits, input logic [31:0] rdata, input logic slverr,
                         input logic drop_psel);
    longint unsigned a;
    bit dec_ok, got, multi, ready;
    int idx, exp_acc, exp_lat, acc, lat;
    logic [31:0] off, seen_paddr, seen_wdata;
    logic [NS-1:0] seen_psel;
    logic [3:0] seen_strb;
    logic [2:0] seen_prot;
    logic seen_wr;
    logic [DW:0] got_rsp, exp_rsp;

    a = 64'(addr);
    dec_ok = (a >= BASE) && (((a - BASE) / REGION) < NS);
    idx = dec_ok ? int'((a - BASE) / REGION) : 0;
    off = dec_ok ? 32'((a - BASE) % REGION) : 32'd0;
    if (!dec_ok) begin
      exp_rsp = {1'b1, 32'd0}; exp_acc = 0; exp_lat = 1; m_dec = 1; m_errs++;
    end else if (waits >= TMO) begin
      exp_rsp = {1'b1, 32'd0}; exp_acc = TMO; exp_lat = 2 + TMO; m_tmo = 1; m_errs++;
    end else begin
      exp_rsp = {slverr, rdata}; exp_acc = waits + 1; exp_lat = 3 + waits;
      if (slverr) begin m_slv = 1; m_errs++; end
    end
    exp_q.push_back(exp_rsp);

    bus.s_apb_paddr = addr; bus.s_apb_psel = 1; bus.s_apb_penable = 0; bus.s_apb_pwrite = wr;
    bus.s_apb_pwdata = wdata; bus.s_apb_pstrb = strb; bus.s_apb_pprot = prot;
    for (int i = 0; i < NS; i++) bus.m_apb_prdata[i*DW +: DW] = (i == idx) ? rdata : (32'hDEAD_0000 | 32'(i));
    @(posedge clk);
    @(negedge clk);
    lat = 1; acc = 0; got = 0; multi = 0; seen_psel = '0;
    seen_paddr = '0; seen_wdata = '0; seen_strb = '0; seen_prot = '0; seen_wr = 0; got_rsp = '0;
    if (drop_psel) begin bus.s_apb_psel = 0; bus.s_apb_penable = 0; end
    else bus.s_apb_penable = 1;
    while (!got && lat < 40) begin
      if ($countones(bus.m_apb_psel) > 1) multi = 1;
      if (lat == 1) check({tag, ".busy"}, 64'(out_status[0]), 64'd1);
      if (bus.s_apb_pready) begin
        got = 1;
        got_rsp = {bus.s_apb_pslverr, bus.s_apb_prdata};
      end else begin
        if (bus.m_apb_psel != '0 && !bus.m_apb_penable) begin
          seen_psel = bus.m_apb_psel; seen_paddr = bus.m_apb_paddr; seen_wdata = bus.m_apb_pwdata;
          seen_strb = bus.m_apb_pstrb; seen_prot = bus.m_apb_pprot; seen_wr = bus.m_apb_pwrite;
        end
        if (bus.m_apb_psel != '0 && bus.m_apb_penable) acc++;
        ready = dec_ok && bus.m_apb_penable && bus.m_apb_psel[idx] && (acc > waits);
        bus.m_apb_pready  = ready ? oh(idx) : '0;
        bus.m_apb_pslverr = (ready && slverr) ? oh(idx) : '0;
        @(negedge clk);
        lat++;
      end
    end
    check({tag, ".done"}, 64'(got), 64'd1);
    check({tag, ".resp"}, 64'(got_rsp), 64'(exp_q.pop_front()));
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".access_cycles"}, 64'(acc), 64'(exp_acc));
    check({tag, ".psel"}, 64'(seen_psel), dec_ok ? 64'(oh(idx)) : 64'd0);
    check({tag, ".onehot"}, 64'(multi), 64'd0);
    if (dec_ok) begin
      check({tag, ".paddr"}, 64'(seen_paddr), 64'(off));
      check({tag, ".pstrb"}, 64'(seen_strb), wr ? 64'(strb) : 64'd0);
      check({tag, ".pwrite"}, 64'(seen_wr), 64'(wr));
      check({tag, ".pwdata"}, 64'(seen_wdata), 64'(wdata));
      check({tag, ".pprot"}, 64'(seen_prot), 64'(prot));
    end
    bus.m_apb_pready = '0; bus.m_apb_pslverr = '0;
    bus.s_apb_psel = 0; bus.s_apb_penable = 0;
    @(negedge clk);
    check({tag, ".pready_one_cycle"}, 64'(bus.s_apb_pready), 64'd0);
    check({tag, ".prdata_idle"}, 64'(bus.s_apb_prdata), 64'd0);
    check({tag, ".psel_idle"}, 64'({bus.m_apb_psel, bus.m_apb_penable}), 64'd0);
    check({tag, ".state_idle"}, 64'(dbg_state), 64'd0);
    check({tag, ".status"}, 64'(out_status), 64'(exp_status()));
    check({tag, ".err_count"}, 64'(out_err_count), 64'(exp_errcnt()));
  endtask

  initial begin
    idle_inputs();
    model_clear();
    reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.pready", 64'(bus.s_apb_pready), 64'd0);
    check("reset.pslverr", 64'(bus.s_apb_pslverr), 64'd0);
    check("reset.prdata", 64'(bus.s_apb_prdata), 64'd0);
    check("reset.psel", 64'(bus.m_apb_psel), 64'd0);
    check("reset.penable", 64'(bus.m_apb_penable), 64'd0);
    check("reset.paddr", 64'(bus.m_apb_paddr), 64'd0);
    check("reset.err_count", 64'(out_err_count), 64'd0);
    check("reset.status", 64'(out_status), 64'd0);
    check("reset.state", 64'(dbg_state), 64'd0);

    // first transfer starts in the very cycle reset is released
    reset = 1;
    do_xfer("wr_slave1", 32'h0000_1004, 1'b1, 32'hCAFE_0001, 4'hF, 3'd0, 0, 32'h0BAD_0001, 1'b0, 1'b0);
    do_xfer("rd_slave3_wait5", 32'h0000_3010, 1'b0, 32'h0, 4'hF, 3'd2, 5, 32'h1234_5678, 1'b0, 1'b0);
    do_xfer("decerr_4000", 32'h0000_4000, 1'b1, 32'h5555_AAAA, 4'h3, 3'd1, 0, 32'h0, 1'b0, 1'b0);
    check("decerr_4000.err_count_is_1", 64'(out_err_count), 64'd1);
    check("decerr_4000.decerr_seen", 64'(out_status[2]), 64'd1);
    do_xfer("timeout_slave0", 32'h0000_0008, 1'b0, 32'h0, 4'h0, 3'd0, 1000, 32'h7777_7777, 1'b0, 1'b0);
    check("timeout_slave0.timeout_seen", 64'(out_status[3]), 64'd1);
    do_xfer("ready_last_cycle", 32'h0000_2FFC, 1'b0, 32'h0, 4'h0, 3'd7, TMO - 1, 32'hA5A5_5A5A, 1'b0, 1'b0);
    do_xfer("slverr_slave2", 32'h0000_2100, 1'b1, 32'h0102_0304, 4'h6, 3'd4, 2, 32'h0, 1'b1, 1'b0);
    check("slverr_slave2.slverr_seen", 64'(out_status[1]), 64'd1);
    do_xfer("psel_drop", 32'h0000_2ABC, 1'b1, 32'h1357_9BDF, 4'hC, 3'd3, 3, 32'h2468_ACE0, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      if ($urandom_range(0, 5) == 0) ra = $urandom_range(32'hFFFF_FFFF, 32'h0000_4000);
      else ra = (32'($urandom_range(0, NS - 1)) << SAB) | (32'($urandom_range(0, 1023)) << 2);
      do_xfer($sformatf("rnd%0d", n), ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), $urandom_range(0, TMO + 1), $urandom,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    // reset in the middle of an ACCESS phase to slave 2 that never answers
    bus.s_apb_paddr = 32'h0000_2000; bus.s_apb_psel = 1; bus.s_apb_penable = 0; bus.s_apb_pwrite = 0;
    @(posedge clk);
    @(negedge clk);
    bus.s_apb_penable = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid.in_access", 64'({bus.m_apb_psel, bus.m_apb_penable}), 64'({oh(2), 1'b1}));
    reset = 0;
    @(negedge clk);
    check("rst_mid.psel", 64'(bus.m_apb_psel), 64'd0);
    check("rst_mid.penable", 64'(bus.m_apb_penable), 64'd0);
    check("rst_mid.pready", 64'(bus.s_apb_pready), 64'd0);
    check("rst_mid.state", 64'(dbg_state), 64'd0);
    check("rst_mid.err_count", 64'(out_err_count), 64'd0);
    check("rst_mid.status", 64'(out_status), 64'd0);
    bus.s_apb_psel = 0; bus.s_apb_penable = 0;
    model_clear();
    reset = 1;
    do_xfer("after_reset", 32'h0000_0100, 1'b1, 32'hFEED_BEEF, 4'h1, 3'd0, 1, 32'h0, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      do_xfer($sformatf("sat%0d", n), $urandom_range(32'hFFFF_FFFF, 32'h0000_4000), 1'b0, 32'h0,
              4'h0, 3'd0, 0, 32'h0, 1'b0, 1'b0);
    end
    check("saturate.err_count", 64'(out_err_count), 64'd255);

    check("scoreboard.empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
